// File: rtl/timebase_pkg.sv
// -----------------------------------------------------------------------------
// timebase_pkg
// Shared definitions for the mains-derived timebase generator: default tick
// count, channel output modes and the width helpers used to size the counter
// and the channel-select port.
// -----------------------------------------------------------------------------
package timebase_pkg;

    // 50 Hz mains input: 25 rising edges make half a second.
    localparam int HALF_TICKS_DEFAULT = 25;
    localparam int NUM_CH_DEFAULT     = 4;
    localparam int PW_DEFAULT         = 8;

    // Per-channel output behaviour.
    typedef enum logic {
        MODE_TOGGLE = 1'b0,   // 50 % square wave, wrap on the rising edge
        MODE_PULSE  = 1'b1    // single-cycle strobe once per full period
    } mode_e;

    // Counter width large enough for the largest terminal count,
    // HALF_TICKS * (2^PW - 1) - 1. Evaluated in 64 bits so that the
    // maximum period cannot overflow during elaboration.
    function automatic int cnt_width(input int half_ticks, input int pw);
        longint max_ticks;
        int     w;
        max_ticks = longint'(half_ticks) * ((longint'(1) << pw) - longint'(1));
        w         = $clog2(max_ticks);
        return (w < 1) ? 1 : w;
    endfunction

    // Channel-select width; a single-channel build still gets a 1-bit port.
    function automatic int sel_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/timebase_chan.sv
// -----------------------------------------------------------------------------
// timebase_chan
// One divider channel: configuration register (period, mode, precomputed
// terminal count), tick counter, half-period phase bit and registered
// clk_out / wrap outputs.
//
// Optional feature: when the macro TIMEBASE_RESYNC_EN is defined the channel
// gets an i_resync input that restarts it from count 0 together with every
// other channel. Without the macro neither the port nor the logic exists.
// -----------------------------------------------------------------------------
module timebase_chan
    import timebase_pkg::*;
#(
    parameter int HALF_TICKS = HALF_TICKS_DEFAULT,
    parameter int PW         = PW_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [PW-1:0] i_period,
    input  logic          i_mode,
`ifdef TIMEBASE_RESYNC_EN
    input  logic          i_resync,
`endif
    output logic          o_clk_out,
    output logic          o_wrap
);

    localparam int            CW   = cnt_width(HALF_TICKS, PW);
    localparam logic [CW-1:0] HT_C = CW'(HALF_TICKS);

    // Registered channel state.
    logic [PW-1:0] r_cfg_period;
    mode_e         r_cfg_mode;
    logic [CW-1:0] r_term;
    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          r_out;
    logic          r_wrap;

    // Next-state values.
    logic [PW-1:0] w_cfg_period_nx;
    mode_e         w_cfg_mode_nx;
    logic [CW-1:0] w_term_nx;
    logic [CW-1:0] w_cnt_nx;
    logic          w_phase_nx;
    logic          w_out_nx;
    logic          w_wrap_nx;

    logic [CW-1:0] w_load_term;
    logic          w_enabled;
    logic          w_at_term;

    // The multiply lives only on the load path; the counter just compares
    // against the stored result. Arithmetic is unsigned and CW bits wide, which
    // holds HALF_TICKS * (2^PW - 1) - 1 exactly.
    assign w_load_term = (HT_C * CW'(i_period)) - CW'(1);
    assign w_enabled   = |r_cfg_period;
    assign w_at_term   = (r_cnt == r_term);

    // Next-state logic: load beats alignment, alignment beats counting.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path leaves a signal unassigned and no latch is inferred.
        w_cfg_period_nx = r_cfg_period;
        w_cfg_mode_nx   = r_cfg_mode;
        w_term_nx       = r_term;
        w_cnt_nx        = r_cnt;
        w_phase_nx      = r_phase;
        w_out_nx        = r_out;
        w_wrap_nx       = 1'b0;

        if (i_load) begin
            // New configuration; the channel restarts from zero and a
            // coincident terminal count is dropped.
            w_cfg_period_nx = i_period;
            w_cfg_mode_nx   = mode_e'(i_mode);
            w_term_nx       = w_load_term;
            w_cnt_nx        = '0;
            w_phase_nx      = 1'b0;
            w_out_nx        = 1'b0;
`ifdef TIMEBASE_RESYNC_EN
        end else if (i_resync) begin
            // Align with all other channels: restart from count 0, output low.
            w_cnt_nx   = '0;
            w_phase_nx = 1'b0;
            w_out_nx   = 1'b0;
`endif
        end else if (!w_enabled) begin
            // Period 0 parks the channel with everything held low.
            w_cnt_nx   = '0;
            w_phase_nx = 1'b0;
            w_out_nx   = 1'b0;
        end else if (w_at_term) begin
            w_cnt_nx = '0;
            if (r_cfg_mode == MODE_TOGGLE) begin
                // Half period elapsed: flip the square wave, flag the rise.
                w_out_nx  = ~r_out;
                w_wrap_nx = ~r_out;
            end else begin
                // Two terminal counts per strobe; fire on the second one.
                w_phase_nx = ~r_phase;
                w_out_nx   = r_phase;
                w_wrap_nx  = r_phase;
            end
        end else begin
            w_cnt_nx = r_cnt + CW'(1);
            if (r_cfg_mode == MODE_PULSE) begin
                w_out_nx = 1'b0;
            end
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: the configuration registers are reset as well, to a 1 s
            // square wave, so the block produces a usable timebase without
            // ever being loaded.
            r_cfg_period <= PW'(1);
            r_cfg_mode   <= MODE_TOGGLE;
            r_term       <= CW'(HALF_TICKS - 1);
            r_cnt        <= '0;
            r_phase      <= 1'b0;
            r_out        <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed above, whatever the statement order.
            r_cfg_period <= w_cfg_period_nx;
            r_cfg_mode   <= w_cfg_mode_nx;
            r_term       <= w_term_nx;
            r_cnt        <= w_cnt_nx;
            r_phase      <= w_phase_nx;
            r_out        <= w_out_nx;
            r_wrap       <= w_wrap_nx;
        end
    end

    assign o_clk_out = r_out;
    assign o_wrap    = r_wrap;

endmodule

// File: rtl/timebase_gen.sv
// -----------------------------------------------------------------------------
// timebase_gen
// Mains-locked multi-channel timebase. Each of NUM_CH channels divides clk_in
// down to a programmable whole number of seconds and emits either a square
// wave or a one-cycle strobe, plus a wrap strobe at every full period.
//
// Optional feature: define TIMEBASE_RESYNC_EN to add the resync input, which
// restarts every channel from count 0 in the same cycle.
// -----------------------------------------------------------------------------
module timebase_gen
    import timebase_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEFAULT,
    parameter int HALF_TICKS = HALF_TICKS_DEFAULT,
    parameter int PW         = PW_DEFAULT
) (
    input  logic                         clk_in,
    input  logic                         rst,
    input  logic                         load,
    input  logic [sel_width(NUM_CH)-1:0] ch_sel,
    input  logic [PW-1:0]                period_in,
    input  logic                         mode_in,
`ifdef TIMEBASE_RESYNC_EN
    input  logic                         resync,
`endif
    output logic [NUM_CH-1:0]            clk_out,
    output logic [NUM_CH-1:0]            wrap
);

    localparam int SEL_W = sel_width(NUM_CH);

    logic [NUM_CH-1:0] w_load_ch;

    // One-hot load decode; a select beyond the last channel matches nothing.
    always_comb begin
        w_load_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load && (ch_sel == SEL_W'(i))) begin
                w_load_ch[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        timebase_chan #(
            .HALF_TICKS (HALF_TICKS),
            .PW         (PW)
        ) u_chan (
            .i_clk      (clk_in),
            .i_rst      (rst),
            .i_load     (w_load_ch[g]),
            .i_period   (period_in),
            .i_mode     (mode_in),
`ifdef TIMEBASE_RESYNC_EN
            .i_resync   (resync),
`endif
            .o_clk_out  (clk_out[g]),
            .o_wrap     (wrap[g])
        );
    end

endmodule

// File: tb/tb_timebase_gen.sv
// -----------------------------------------------------------------------------
// tb_timebase_gen
// Three-channel build (so an out-of-range ch_sel is representable) with the
// default 25 ticks per half second and 8-bit periods. A closed-form model of
// each channel predicts clk_out/wrap for every cycle; predictions are queued
// after each edge and compared on the following falling edge. A vector table
// of loads is checked against hand-derived rise/high/period figures, and short
// hand-written sequences cover reset, terminal-count load and resync.
// -----------------------------------------------------------------------------
module tb_timebase_gen;
    import timebase_pkg::*;

    localparam int NUM_CH = 3;
    localparam int HT     = 25;
    localparam int PW     = 8;
    localparam int SEL_W  = $clog2(NUM_CH);

    logic              clk_in = 1'b0;
    logic              rst;
    logic              load;
    logic [SEL_W-1:0]  ch_sel;
    logic [PW-1:0]     period_in;
    logic              mode_in;
`ifdef TIMEBASE_RESYNC_EN
    logic              resync;
`endif
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] wrap;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: per channel period, mode and the edge count at
    // which its counter last restarted from zero.
    int m_p   [NUM_CH];
    int m_mode[NUM_CH];
    int m_org [NUM_CH];
    bit m_rst;

    // Stimulus applied at the coming edge, seen by the model.
    bit pend_load;
    int pend_ch, pend_p, pend_mode;
    bit pend_resync;

    typedef struct {
        logic [NUM_CH-1:0] out;
        logic [NUM_CH-1:0] wrap;
    } sb_item_t;
    sb_item_t sb_q[$];

    typedef struct {
        int ch;
        int period;
        int mode;
        int budget;
        int exp_rise;
        int exp_high;
        int exp_per;
    } vec_t;

    always #5 clk_in = ~clk_in;

    timebase_gen #(
        .NUM_CH     (NUM_CH),
        .HALF_TICKS (HT),
        .PW         (PW)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .load       (load),
        .ch_sel     (ch_sel),
        .period_in  (period_in),
        .mode_in    (mode_in),
`ifdef TIMEBASE_RESYNC_EN
        .resync     (resync),
`endif
        .clk_out    (clk_out),
        .wrap       (wrap)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0d, want %0d (cycle %0d)",
                         name, $signed(act), $signed(exp), cyc);
        end
    endtask

    // Closed form: t edges after restart, n = ticks per half period.
    // Toggle: out = floor(t/n) odd, wrap when t mod 2n == n.
    // Pulse : out = wrap = (t > 0 and t mod 2n == 0).
    function automatic logic [1:0] model_bits(input int ch);
        int   t, n;
        logic o, w;
        if (m_rst) return 2'b00;
        n = HT * m_p[ch];
        if (n == 0) return 2'b00;
        t = cyc - m_org[ch];
        if (m_mode[ch] == 0) begin
            o = ((t / n) % 2) == 1;
            w = (t % (2 * n)) == n;
        end else begin
            o = (t > 0) && ((t % (2 * n)) == 0);
            w = o;
        end
        return {o, w};
    endfunction

    // Advance one edge, update the model with what the DUT sampled, queue the
    // prediction for this cycle.
    task automatic step();
        sb_item_t   it;
        logic [1:0] b;
        @(posedge clk_in);
        cyc++;
        if (!m_rst) begin
            if (pend_resync)
                for (int c = 0; c < NUM_CH; c++) m_org[c] = cyc;
            if (pend_load && pend_ch < NUM_CH) begin
                m_p[pend_ch]    = pend_p;
                m_mode[pend_ch] = pend_mode;
                m_org[pend_ch]  = cyc;
            end
        end
        pend_load   = 1'b0;
        pend_resync = 1'b0;
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            b          = model_bits(c);
            it.out[c]  = b[1];
            it.wrap[c] = b[0];
        end
        sb_q.push_back(it);
    endtask

    // Scoreboard compare, away from the active edge.
    always @(negedge clk_in) begin
        sb_item_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_clk_out", 32'(clk_out), 32'(e.out));
            check("sb_wrap", 32'(wrap), 32'(e.wrap));
        end
    end

    task automatic do_load(input int ch, input int p, input int mode);
        load      = 1'b1;
        ch_sel    = SEL_W'(ch);
        period_in = PW'(p);
        mode_in   = mode[0];
        pend_load = 1'b1;
        pend_ch   = ch;
        pend_p    = p;
        pend_mode = mode;
        step();
        load      = 1'b0;
    endtask

    task automatic release_reset();
        rst   = 1'b0;
        m_rst = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_p[c]    = 1;
            m_mode[c] = 0;
            m_org[c]  = cyc;
        end
    endtask

    // Edges (from now) of the first rise, its high time and the rise-to-rise
    // period; -1 for anything not seen within the budget.
    task automatic measure(input int ch, input int budget,
                           output int t_rise, output int t_high, output int t_per);
        logic prev, cur;
        bit   done;
        t_rise = -1;
        t_high = -1;
        t_per  = -1;
        done   = 1'b0;
        prev   = clk_out[ch];
        for (int t = 1; t <= budget && !done; t++) begin
            step();
            cur = clk_out[ch];
            if (!prev && cur) begin
                if (t_rise < 0) t_rise = t;
                else begin
                    t_per = t - t_rise;
                    done  = 1'b1;
                end
            end else if (prev && !cur && t_rise >= 0 && t_high < 0) begin
                t_high = t - t_rise;
            end
            prev = cur;
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   t_r, t_h, t_p;

        vecs[0] = '{2,   2, 1,   250,  100,    1,   100};
        vecs[1] = '{1,   0, 0,  1000,   -1,   -1,    -1};
        vecs[2] = '{1,   1, 0,   150,   25,   25,    50};
        vecs[3] = '{0,   1, 1,   150,   50,    1,    50};
        vecs[4] = '{2,   3, 0,   400,   75,   75,   150};
        vecs[5] = '{0,   5, 1,   600,  250,    1,   250};
        vecs[6] = '{1, 255, 0, 20000, 6375, 6375, 12750};

        rst         = 1'b1;
        load        = 1'b0;
        ch_sel      = '0;
        period_in   = '0;
        mode_in     = 1'b0;
`ifdef TIMEBASE_RESYNC_EN
        resync      = 1'b0;
`endif
        m_rst       = 1'b1;
        pend_load   = 1'b0;
        pend_resync = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_p[c] = 1; m_mode[c] = 0; m_org[c] = 0;
        end

        // Reset state and default 1 s square wave after release.
        repeat (3) step();
        check("reset_clk_out", 32'(clk_out), 32'd0);
        check("reset_wrap", 32'(wrap), 32'd0);
        release_reset();
        measure(0, 200, t_r, t_h, t_p);
        check("default_rise", t_r, 25);
        check("default_high", t_h, 25);
        check("default_period", t_p, 50);

        // Table of loads.
        for (int i = 0; i < 7; i++) begin
            do_load(vecs[i].ch, vecs[i].period, vecs[i].mode);
            measure(vecs[i].ch, vecs[i].budget, t_r, t_h, t_p);
            check($sformatf("vec%0d_rise", i), t_r, vecs[i].exp_rise);
            check($sformatf("vec%0d_high", i), t_h, vecs[i].exp_high);
            check($sformatf("vec%0d_period", i), t_p, vecs[i].exp_per);
        end

        // Asynchronous reset 37 cycles into a 3 s channel.
        do_load(0, 3, 0);
        repeat (37) step();
        #1;
        rst   = 1'b1;
        m_rst = 1'b1;
        sb_q.delete();
        #1;
        check("midrst_clk_out", 32'(clk_out), 32'd0);
        check("midrst_wrap", 32'(wrap), 32'd0);
        repeat (2) step();
        release_reset();
        measure(0, 200, t_r, t_h, t_p);
        check("midrst_rise", t_r, 25);
        check("midrst_period", t_p, 50);

        // Load on the very edge where channel 0 would have toggled.
        do_load(0, 1, 0);
        repeat (24) step();
        do_load(0, 2, 0);
        check("termload_clk_out0", 32'(clk_out[0]), 32'd0);
        check("termload_wrap0", 32'(wrap[0]), 32'd0);
        measure(0, 300, t_r, t_h, t_p);
        check("termload_rise", t_r, 50);
        check("termload_high", t_h, 50);
        check("termload_period", t_p, 100);

        // Out-of-range select must leave every channel alone.
        do_load(3, 0, 1);
        repeat (300) step();

`ifdef TIMEBASE_RESYNC_EN
        begin
            int r0, r1;
            do_load(0, 1, 0);
            repeat (10) step();
            do_load(1, 2, 0);
            repeat (60) step();
            resync      = 1'b1;
            pend_resync = 1'b1;
            step();
            resync      = 1'b0;
            check("resync_clk_out", 32'(clk_out), 32'd0);
            check("resync_wrap", 32'(wrap), 32'd0);
            r0 = -1;
            r1 = -1;
            for (int t = 1; t <= 60; t++) begin
                step();
                if (r0 < 0 && clk_out[0]) r0 = t;
                if (r1 < 0 && clk_out[1]) r1 = t;
            end
            check("resync_rise0", r0, 25);
            check("resync_rise1", r1, 50);
        end
`endif

        repeat (2) @(negedge clk_in);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timebase_gen.md
TIMEBASE_GEN -- requirements
Module: timebase_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent divider channels (1..8).
REQ-002 SHALL have parameter HALF_TICKS, default 25: clk_in cycles per half second (50 Hz mains input).
REQ-003 SHALL have parameter PW, default 8: width of the per-channel period field, in seconds.
REQ-004 SHALL have port clk_in, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port load, input, 1 bit: one-cycle strobe that writes the configuration of one channel.
REQ-007 SHALL have port ch_sel, input, clog2(NUM_CH) bits: target channel of load.
REQ-008 SHALL have port period_in, input, PW bits: period in seconds; 0 means the channel is disabled.
REQ-009 SHALL have port mode_in, input, 1 bit: 0 = toggle (50 % square wave), 1 = pulse (one-cycle strobe).
REQ-010 SHALL have port clk_out, output, NUM_CH bits: per-channel divided output.
REQ-011 SHALL have port wrap, output, NUM_CH bits: per-channel one-cycle strobe at each full-period boundary.

Function
REQ-012 Each channel SHALL hold registered cfg_period, cfg_mode, cnt and out state.
REQ-013 Terminal count SHALL be HALF_TICKS*cfg_period-1, computed at load time and stored; no multiply in the count path.
REQ-014 Toggle mode: cnt SHALL increment each cycle; at terminal count cnt->0 and clk_out toggles; period = 2*HALF_TICKS*P cycles.
REQ-015 Toggle mode: wrap SHALL pulse for one cycle in the cycle clk_out rises.
REQ-016 Pulse mode: clk_out SHALL be high for exactly one cycle every 2*HALF_TICKS*P cycles; wrap equals clk_out.
REQ-017 Pulse mode: a half-period phase bit SHALL extend the count to two terminal counts per output strobe.
REQ-018 cfg_period=0: cnt, clk_out and wrap SHALL be held at 0.
REQ-019 load SHALL take effect on the next clk_in edge: cnt, phase and clk_out of the target channel cleared; other channels undisturbed.
REQ-020 load to a channel in the same cycle as its terminal count: load SHALL win, and no toggle or wrap occurs that cycle.
REQ-021 ch_sel >= NUM_CH SHALL be ignored.
REQ-022 Counter width SHALL be clog2(HALF_TICKS*(2^PW-1)); arithmetic at load SHALL be unsigned, with no overflow at max period.

Reset
REQ-023 rst high SHALL immediately clear all cnt, phase, clk_out and wrap bits to 0.
REQ-024 rst high SHALL set cfg_period of every channel to 1 and cfg_mode to 0, giving a 1 s square wave after release.
REQ-025 rst asserted mid-period SHALL discard partial counts; counting restarts from 0 on the first edge after deassertion.

Configuration
REQ-026 Macro TIMEBASE_RESYNC_EN defined: input port resync (1 bit) SHALL exist and, when high, clear cnt, phase and clk_out of all enabled channels in the same cycle, aligning them.
REQ-027 Macro TIMEBASE_RESYNC_EN absent: port resync SHALL NOT exist and no alignment logic SHALL be generated.
REQ-028 load and resync in the same cycle: the target channel SHALL take the new configuration, and all channels SHALL restart from 0.

Structure
REQ-029 Package timebase_pkg SHALL hold the HALF_TICKS default, the mode encodings MODE_TOGGLE/MODE_PULSE, and the counter-width function.
REQ-030 Sub-module timebase_chan (one channel: config register, counter, phase, output) SHALL be instantiated NUM_CH times by generate.

Verification
REQ-031 Reset release, defaults -> every clk_out rises at cycle 25, falls at cycle 50, and has period 50 cycles.
REQ-032 load ch 2, P=2, mode 1 -> clk_out[2] high for 1 cycle every 100 cycles, first at cycle 100 after load; other channels unchanged.
REQ-033 load ch 1, P=0 -> clk_out[1] and wrap[1] stay 0 for 1000 cycles; reload P=1 restores a 50-cycle square wave.
REQ-034 load during ch 0 cycle 24 (terminal) -> no toggle; the new period starts from 0.
REQ-035 rst pulse at cycle 37 of a P=3 channel -> outputs clear immediately; after release the channel runs at a 50-cycle period (defaults).
REQ-036 TIMEBASE_RESYNC_EN defined, channels at phases P=1/P=2, resync pulse -> all clk_out low the next cycle, and the first rises land at +25 and +50.
